// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer for the digit-scroll game
// Optional answer timeout: define GAME_ROUND_CTRL_TIMEOUT_EN.
module game_round_ctrl #(
    parameter int ROUNDS         = 20,
    parameter int TIMEOUT_FRAMES = 300,
    parameter int SCORE_W        = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_frame_tick,
    input  logic               i_digit_valid,
    input  logic [3:0]         i_digit,
    input  logic [3:0]         i_expected_digit,
    input  logic               i_scroll_busy,
    output logic [3:0]         o_digit_answered,
    output logic               o_digit_identified,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_round,
    output logic [9:0]         o_time_left,
    output logic               o_game_over,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ANS = 3'd1,
        S_ISSUE    = 3'd2,
        S_ACK      = 3'd3,
        S_SCROLL   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [9:0]         TIME_LOAD  = 10'(TIMEOUT_FRAMES);
    localparam logic [SCORE_W-1:0] ROUND_LAST = SCORE_W'(ROUNDS);

    state_t             state_q, state_d;
    logic               valid_sync_q, valid_prev_q;
    logic               match_q, match_d;
    logic [3:0]         answer_q, answer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] round_q, round_d;
    logic [9:0]         time_left_q, time_left_d;
    logic [1:0]         ack_ticks_q, ack_ticks_d;
    logic               digit_edge;

    // Edge detector runs in every state so a level held across rounds never counts.
    assign digit_edge = valid_sync_q & ~valid_prev_q;

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        answer_d    = answer_q;
        score_d     = score_q;
        round_d     = round_q;
        time_left_d = time_left_q;
        ack_ticks_d = ack_ticks_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    score_d     = '0;
                    round_d     = '0;
                    time_left_d = TIME_LOAD;
                    state_d     = S_WAIT_ANS;
                end
            end
            S_WAIT_ANS: begin
                if (digit_edge) begin
                    answer_d = i_digit;
                    match_d  = (i_digit == i_expected_digit);
                    state_d  = S_ISSUE;
                end else if (i_frame_tick) begin
                    if (time_left_q != 10'd0) begin
                        time_left_d = time_left_q - 10'd1;
                    end
`ifdef GAME_ROUND_CTRL_TIMEOUT_EN
                    else begin
                        answer_d = 4'hf;
                        match_d  = 1'b0;
                        state_d  = S_ISSUE;
                    end
`endif
                end
            end
            S_ISSUE: begin
                if (match_q && (score_q != {SCORE_W{1'b1}})) begin
                    score_d = score_q + SCORE_W'(1);
                end
                ack_ticks_d = 2'd0;
                state_d     = S_ACK;
            end
            S_ACK: begin
                // Lost-handshake guard: give up waiting for busy after four frames.
                if (i_scroll_busy) begin
                    state_d = S_SCROLL;
                end else if (i_frame_tick) begin
                    if (ack_ticks_q == 2'd3) begin
                        state_d = S_SCROLL;
                    end else begin
                        ack_ticks_d = ack_ticks_q + 2'd1;
                    end
                end
            end
            S_SCROLL: begin
                if (!i_scroll_busy) begin
                    round_d = round_q + SCORE_W'(1);
                    if (round_d == ROUND_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        time_left_d = TIME_LOAD;
                        state_d     = S_WAIT_ANS;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            valid_sync_q <= 1'b0;
            valid_prev_q <= 1'b0;
            match_q      <= 1'b0;
            answer_q     <= 4'd0;
            score_q      <= '0;
            round_q      <= '0;
            time_left_q  <= 10'd0;
            ack_ticks_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            valid_sync_q <= i_digit_valid;
            valid_prev_q <= valid_sync_q;
            match_q      <= match_d;
            answer_q     <= answer_d;
            score_q      <= score_d;
            round_q      <= round_d;
            time_left_q  <= time_left_d;
            ack_ticks_q  <= ack_ticks_d;
        end
    end

    assign o_digit_answered   = answer_q;
    assign o_digit_identified = (state_q == S_ISSUE);
    assign o_score            = score_q;
    assign o_round            = round_q;
    assign o_time_left        = time_left_q;
    assign o_game_over        = (state_q == S_DONE);
    assign o_state            = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

    localparam int ROUNDS = 3;
    localparam int TMO    = 5;

    logic       clk = 1'b0;
    logic       rst_n, start, frame_tick, digit_valid, busy;
    logic [3:0] digit, exp_digit;
    logic [3:0] answered;
    logic       identified, game_over;
    logic [7:0] score, round;
    logic [9:0] time_left;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    game_round_ctrl #(
        .ROUNDS(ROUNDS), .TIMEOUT_FRAMES(TMO), .SCORE_W(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_tick(frame_tick),
        .i_digit_valid(digit_valid), .i_digit(digit), .i_expected_digit(exp_digit),
        .i_scroll_busy(busy), .o_digit_answered(answered),
        .o_digit_identified(identified), .o_score(score), .o_round(round),
        .o_time_left(time_left), .o_game_over(game_over), .o_state(state)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (identified === 1'b1) pulses++;

    typedef struct {
        logic [3:0] d;
        logic [3:0] e;
        int         pre;
        int         blen;
        bit         guard;
        bit         toggle;
        int         exp_time;
        int         exp_score;
        int         exp_round;
        bit         exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic answer_phase(input logic [3:0] d, input logic [3:0] e,
                                input int exp_time, input int exp_score);
        int p0;
        digit_valid = 1'b0;
        cyc();
        cyc();
        chk("wait_state", state, 1);
        chk("time_left", time_left, exp_time);
        p0 = pulses;
        digit = d;
        exp_digit = e;
        digit_valid = 1'b1;
        cyc();
        chk("no_early_pulse", identified, 0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("pulse", identified, 1);
        chk("answer", answered, d);
        chk("tick_dropped", time_left, exp_time);
        cyc();
        chk("pulse_width", identified, 0);
        chk("score", score, exp_score);
        chk("ack_state", state, 3);
        chk("pulse_count", pulses - p0, 1);
    endtask

    task automatic scroll_phase(input int blen, input bit guard, input bit toggle,
                                input int exp_round, input bit exp_done);
        int p0;
        if (guard) begin
            tick_cycles(3);
            chk("ack_hold", state, 3);
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            chk("guard_scroll", state, 4);
            chk("round_hold", round, exp_round - 1);
        end else begin
            cyc();
            chk("ack_wait", state, 3);
            busy = 1'b1;
            cyc();
            chk("scroll_state", state, 4);
            for (int i = 0; i < blen; i++) begin
                if (toggle) digit_valid = i[0];
                frame_tick = (i % 3 == 0);
                cyc();
            end
            frame_tick = 1'b0;
            if (toggle) begin
                digit_valid = 1'b1;
                cyc();
                cyc();
            end
            chk("round_hold", round, exp_round - 1);
            busy = 1'b0;
        end
        cyc();
        chk("round", round, exp_round);
        chk("post_state", state, exp_done ? 5 : 1);
        chk("game_over", game_over, exp_done);
        if (!exp_done) chk("reload", time_left, TMO);
        if (toggle && !exp_done) begin
            p0 = pulses;
            repeat (4) cyc();
            chk("stale_level", state, 1);
            chk("stale_pulse", pulses - p0, 0);
        end
    endtask

    task automatic restart();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_score", score, 0);
        chk("restart_round", round, 0);
        chk("restart_time", time_left, TMO);
        chk("restart_over", game_over, 0);
    endtask

    initial begin
        vec_t tbl[3];
        int   p0, s0, m_score, m_round, m_time, pre;
        logic [3:0] d, e;
        bit   g, t, done;

        tbl[0] = '{d:4'd7, e:4'd7, pre:0, blen:6, guard:1'b0, toggle:1'b1,
                   exp_time:5, exp_score:1, exp_round:1, exp_done:1'b0};
        tbl[1] = '{d:4'd3, e:4'd5, pre:2, blen:1, guard:1'b1, toggle:1'b0,
                   exp_time:3, exp_score:1, exp_round:2, exp_done:1'b0};
        tbl[2] = '{d:4'd0, e:4'd0, pre:5, blen:3, guard:1'b0, toggle:1'b0,
                   exp_time:0, exp_score:2, exp_round:3, exp_done:1'b1};

        rst_n = 1'b0; start = 1'b0; frame_tick = 1'b0; digit_valid = 1'b0;
        busy = 1'b0; digit = 4'd0; exp_digit = 4'd0;
        repeat (3) cyc();
        chk("rst_state", state, 0);
        chk("rst_answer", answered, 0);
        chk("rst_ident", identified, 0);
        chk("rst_score", score, 0);
        chk("rst_round", round, 0);
        chk("rst_time", time_left, 0);
        chk("rst_over", game_over, 0);
        rst_n = 1'b1;
        cyc();

        // Idle ignores ticks and digit edges
        digit_valid = 1'b1;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (3) cyc();
        chk("idle_state", state, 0);
        chk("idle_time", time_left, 0);
        chk("idle_pulses", pulses, 0);

        restart();
        for (int k = 0; k < 3; k++) begin
            tick_cycles(tbl[k].pre);
            answer_phase(tbl[k].d, tbl[k].e, tbl[k].exp_time, tbl[k].exp_score);
            scroll_phase(tbl[k].blen, tbl[k].guard, tbl[k].toggle,
                         tbl[k].exp_round, tbl[k].exp_done);
        end

        digit_valid = 1'b0;
        cyc();
        digit_valid = 1'b1;
        repeat (4) cyc();
        chk("done_hold", state, 5);
        chk("done_score", score, 2);

        restart();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_ignored", state, 1);
        chk("start_ignored_time", time_left, TMO);

        p0 = pulses;
`ifdef GAME_ROUND_CTRL_TIMEOUT_EN
        tick_cycles(TMO);
        chk("tmo_zero", time_left, 0);
        chk("tmo_wait", state, 1);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("tmo_pulse", identified, 1);
        chk("tmo_answer", answered, 4'hf);
        cyc();
        chk("tmo_score", score, 0);
        chk("tmo_pulses", pulses - p0, 1);
        scroll_phase(2, 1'b0, 1'b0, 1, 1'b0);
        s0 = 0;
`else
        tick_cycles(TMO + 3);
        chk("tmo_zero", time_left, 0);
        chk("tmo_wait", state, 1);
        chk("tmo_no_pulse", pulses - p0, 0);
        answer_phase(4'd4, 4'd4, 0, 1);
        scroll_phase(2, 1'b0, 1'b0, 1, 1'b0);
        s0 = 1;
`endif

        // Asynchronous reset while waiting in S_ACK
        answer_phase(4'd2, 4'd2, TMO, s0 + 1);
        p0 = pulses;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_answer", answered, 0);
        chk("arst_ident", identified, 0);
        chk("arst_score", score, 0);
        chk("arst_round", round, 0);
        chk("arst_time", time_left, 0);
        chk("arst_over", game_over, 0);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("arst_no_pulse", pulses - p0, 0);
        chk("arst_idle", state, 0);

        // Randomised games against a round-level score model
        restart();
        m_score = 0;
        m_round = 0;
        for (int k = 0; k < 30; k++) begin
            d = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 1) == 1) ? d : 4'($urandom_range(0, 15));
`ifdef GAME_ROUND_CTRL_TIMEOUT_EN
            pre = $urandom_range(0, TMO);
`else
            pre = $urandom_range(0, TMO + 3);
`endif
            m_time = (pre >= TMO) ? 0 : TMO - pre;
            tick_cycles(pre);
            if (d == e) m_score++;
            answer_phase(d, e, m_time, m_score);
            g = ($urandom_range(0, 3) == 0);
            t = !g && ($urandom_range(0, 1) == 1);
            m_round++;
            done = (m_round == ROUNDS);
            scroll_phase($urandom_range(1, 8), g, t, m_round, done);
            if (done) begin
                restart();
                m_score = 0;
                m_round = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
